// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP multiply arbiter slice.
// State encoding, requester IDs, widths, rounding modes, helpers.
package fp_ctrl_pkg;

  localparam int FP_WIDTH = 32;
  localparam int RM_WIDTH = 2;

  localparam logic [RM_WIDTH-1:0] RM_RNE = 2'b00;
  localparam logic [RM_WIDTH-1:0] RM_RTZ = 2'b01;
  localparam logic [RM_WIDTH-1:0] RM_RUP = 2'b10;
  localparam logic [RM_WIDTH-1:0] RM_RDN = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [FP_WIDTH-1:0] num1;
    logic [FP_WIDTH-1:0] num2;
    logic [RM_WIDTH-1:0] rm;
  } fp_op_t;

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    n = 6'd48;
    for (int i = 0; i < 48; i++)
      if (v[i]) n = 6'(47 - i);
    return n;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// One requester port of the arbiter: request and response handshakes.
// master = requester side, slave = arbiter side.
interface fp_mul_arbiter_if;
  import fp_ctrl_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [FP_WIDTH-1:0] num1;
  logic [FP_WIDTH-1:0] num2;
  logic [RM_WIDTH-1:0] rounding_mode;
  logic                resp_valid;
  logic                resp_ready;
  logic [FP_WIDTH-1:0] result;

  modport master (
    output req_valid, num1, num2,
    output rounding_mode, resp_ready,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, num1, num2,
    input  rounding_mode, resp_ready,
    output req_ready, resp_valid, result
  );

endinterface

// File: rtl/fp_multiplier.sv
// Combinational IEEE754 single-precision multiplier, four rounding modes.
// Handles NaN, inf, zero, subnormal inputs and outputs.
module fp_multiplier
  import fp_ctrl_pkg::*;
(
  input  logic [FP_WIDTH-1:0] num1,
  input  logic [FP_WIDTH-1:0] num2,
  input  logic [RM_WIDTH-1:0] rounding_mode,
  output logic [FP_WIDTH-1:0] result
);

  logic        s;
  logic [7:0]  ea, eb, ea_e, eb_e;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        a_zero, b_zero;
  logic [23:0] ma, mb;

  assign ea = num1[30:23];
  assign eb = num2[30:23];
  assign fa = num1[22:0];
  assign fb = num2[22:0];
  assign s  = num1[31] ^ num2[31];

  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_zero = (ea == 8'd0) && (fa == '0);
  assign b_zero = (eb == 8'd0) && (fb == '0);

  assign ea_e = (ea == 8'd0) ? 8'd1 : ea;
  assign eb_e = (eb == 8'd0) ? 8'd1 : eb;
  assign ma   = {ea != 8'd0, fa};
  assign mb   = {eb != 8'd0, fb};

  logic [47:0]        p, pn, pd, mask;
  logic [5:0]         lz;
  logic signed [11:0] e;
  logic [11:0]        sh_w;
  logic [7:0]         sh, ef;
  logic               g, st, st_x, inc;
  logic               ovf, to_inf;
  logic [30:0]        rnd;

  always_comb begin
    p    = ma * mb;
    lz   = lzc48(p);
    pn   = p << lz;
    e    = $signed({4'd0, ea_e})
         + $signed({4'd0, eb_e})
         - 12'sd126
         - $signed({6'd0, lz});
    sh_w = '0;
    sh   = '0;
    mask = '0;
    st_x = 1'b0;
    pd   = pn;
    ovf  = (e > 12'sd254);
    // Subnormal result: denormalise, keep shifted-out bits as sticky
    if (e < 12'sd1) begin
      sh_w = 12'(12'sd1 - e);
      sh   = (sh_w > 12'd63) ? 8'd63 : sh_w[7:0];
      mask = (48'd1 << sh) - 48'd1;
      st_x = |(pn & mask);
      pd   = pn >> sh;
    end
    ef = pd[47] ? e[7:0] : 8'd0;
    g  = pd[23];
    st = (|pd[22:0]) | st_x;
    inc = 1'b0;
    to_inf = 1'b1;
    unique case (rounding_mode)
      RM_RNE: begin
        inc    = g & (st | pd[24]);
        to_inf = 1'b1;
      end
      RM_RTZ: begin
        inc    = 1'b0;
        to_inf = 1'b0;
      end
      RM_RUP: begin
        inc    = ~s & (g | st);
        to_inf = ~s;
      end
      RM_RDN: begin
        inc    = s & (g | st);
        to_inf = s;
      end
      default: ;
    endcase
    // Mantissa carry ripples into the exponent field
    rnd = {ef, pd[46:24]} + 31'(inc);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      result = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      result = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      result = {s, 31'd0};
    else if (ovf || (rnd[30:23] == 8'hFF))
      result = to_inf ? {s, 8'hFF, 23'd0}
                      : {s, 31'h7F7F_FFFF};
    else
      result = {s, rnd};
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Two-requester round-robin front end for one shared fp_multiplier.
// IDLE grants and captures operands, BUSY waits, RESP holds result.
module fp_mul_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_mul_arbiter_if.slave   a,
  fp_mul_arbiter_if.slave   b,
  output logic              busy
);

  localparam logic [3:0] LAT = 4'(MUL_LATENCY);

  state_t              state;
  req_id_t             ptr, owner;
  logic [3:0]          cnt;
  fp_op_t              op;
  logic [FP_WIDTH-1:0] res, mul_res;
  logic                a_rv, b_rv;
  logic                grant_b, take, own_rdy;

  assign grant_b = b.req_valid
                 & (~a.req_valid | (ptr == REQ_B));

  assign a.req_ready = rst_n & (state == IDLE)
                     & a.req_valid & ~grant_b;
  assign b.req_ready = rst_n & (state == IDLE)
                     & grant_b;
  assign take = a.req_ready | b.req_ready;

  assign own_rdy = (owner == REQ_A) ? a.resp_ready
                                    : b.resp_ready;

  assign a.resp_valid = a_rv;
  assign b.resp_valid = b_rv;
  assign a.result     = res;
  assign b.result     = res;

  fp_multiplier u_mul (
    .num1          (op.num1),
    .num2          (op.num2),
    .rounding_mode (op.rm),
    .result        (mul_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= REQ_A;
      owner <= REQ_A;
      cnt   <= '0;
      op    <= '0;
      res   <= '0;
      a_rv  <= 1'b0;
      b_rv  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            op <= grant_b
              ? '{b.num1, b.num2, b.rounding_mode}
              : '{a.num1, a.num2, a.rounding_mode};
            owner <= grant_b ? REQ_B : REQ_A;
            cnt   <= LAT;
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            res   <= mul_res;
            state <= RESP;
            a_rv  <= (owner == REQ_A);
            b_rv  <= (owner == REQ_B);
          end
        end
        RESP: begin
          // Handshake hands priority to the other requester
          if (own_rdy) begin
            state <= IDLE;
            busy  <= 1'b0;
            a_rv  <= 1'b0;
            b_rv  <= 1'b0;
            ptr   <= (owner == REQ_A) ? REQ_B : REQ_A;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          a_rv  <= 1'b0;
          b_rv  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter, default MUL_LATENCY of 1.
// Expected products are hand-computed IEEE754 values.
module tb_fp_mul_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   errors;

  fp_mul_arbiter_if ia ();
  fp_mul_arbiter_if ib ();

  fp_mul_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (ia),
    .b     (ib),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic serve_a(input string tag,
                         input logic [31:0] n1,
                         input logic [31:0] n2,
                         input logic [1:0]  rm,
                         input logic [31:0] exp);
    ia.num1          = n1;
    ia.num2          = n2;
    ia.rounding_mode = rm;
    ia.req_valid     = 1'b1;
    ia.resp_ready    = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(ia.req_ready), 32'd1);
    step();
    ia.req_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rv_early"}, 32'(ia.resp_valid), 32'd0);
    step();
    chk({tag, "_rv"}, 32'(ia.resp_valid), 32'd1);
    chk({tag, "_res"}, ia.result, exp);
    chk({tag, "_b_rv"}, 32'(ib.resp_valid), 32'd0);
    step();
    chk({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ia.req_valid = 1'b1;
    ia.num1 = '0;
    ia.num2 = '0;
    ia.rounding_mode = '0;
    ia.resp_ready = 1'b0;
    ib.req_valid = 1'b0;
    ib.num1 = '0;
    ib.num2 = '0;
    ib.rounding_mode = '0;
    ib.resp_ready = 1'b0;
    step();
    step();
    chk("rst_a_ready", 32'(ia.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_rv", 32'(ia.resp_valid), 32'd0);
    chk("rst_b_rv", 32'(ib.resp_valid), 32'd0);
    chk("rst_result", ia.result, 32'd0);
    ia.req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    serve_a("mul2x3", 32'h4000_0000, 32'h4040_0000,
            2'b00, 32'h40C0_0000);
    chk("mul2x3_b_ready", 32'(ib.req_ready), 32'd0);

    serve_a("rne", 32'h3FE8_7CF5, 32'h3F0C_F1E1,
            2'b00, 32'h3F80_0000);
    serve_a("rtz", 32'h3FE8_7CF5, 32'h3F0C_F1E1,
            2'b01, 32'h3F7F_FFFF);
    serve_a("rup", 32'h3FE8_7CF5, 32'h3F0C_F1E1,
            2'b10, 32'h3F80_0000);
    serve_a("rdn", 32'h3FE8_7CF5, 32'h3F0C_F1E1,
            2'b11, 32'h3F7F_FFFF);

    // Collision: pointer restarts at A after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ia.num1 = 32'h3F80_0000;
    ia.num2 = 32'h3F80_0000;
    ia.rounding_mode = 2'b00;
    ib.num1 = 32'h4000_0000;
    ib.num2 = 32'h4000_0000;
    ib.rounding_mode = 2'b00;
    ia.req_valid = 1'b1;
    ib.req_valid = 1'b1;
    ia.resp_ready = 1'b1;
    ib.resp_ready = 1'b1;
    #1;
    chk("col1_a_ready", 32'(ia.req_ready), 32'd1);
    chk("col1_b_ready", 32'(ib.req_ready), 32'd0);
    step();
    step();
    chk("col1_a_rv", 32'(ia.resp_valid), 32'd1);
    chk("col1_a_res", ia.result, 32'h3F80_0000);
    chk("col1_b_rv", 32'(ib.resp_valid), 32'd0);
    chk("col1_resp_a_ready", 32'(ia.req_ready), 32'd0);
    chk("col1_resp_b_ready", 32'(ib.req_ready), 32'd0);
    step();
    chk("col2_b_ready", 32'(ib.req_ready), 32'd1);
    chk("col2_a_ready", 32'(ia.req_ready), 32'd0);
    step();
    step();
    chk("col2_b_rv", 32'(ib.resp_valid), 32'd1);
    chk("col2_b_res", ib.result, 32'h4080_0000);
    chk("col2_a_rv", 32'(ia.resp_valid), 32'd0);
    step();
    chk("col3_a_ready", 32'(ia.req_ready), 32'd1);
    chk("col3_b_ready", 32'(ib.req_ready), 32'd0);
    step();
    step();
    chk("col3_a_rv", 32'(ia.resp_valid), 32'd1);
    chk("col3_a_res", ia.result, 32'h3F80_0000);
    ia.req_valid = 1'b0;
    ib.req_valid = 1'b0;
    step();

    // Back-pressure with operand churn and a waiting B request
    ia.num1 = 32'h4040_0000;
    ia.num2 = 32'h4040_0000;
    ia.rounding_mode = 2'b00;
    ia.req_valid = 1'b1;
    ia.resp_ready = 1'b0;
    #1;
    chk("hold_a_ready", 32'(ia.req_ready), 32'd1);
    step();
    ia.req_valid = 1'b0;
    ia.num1 = 32'h4000_0000;
    ia.num2 = 32'h4000_0000;
    ia.rounding_mode = 2'b01;
    ib.num1 = 32'h4000_0000;
    ib.num2 = 32'h4040_0000;
    ib.rounding_mode = 2'b00;
    ib.req_valid = 1'b1;
    ib.resp_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_a_rv", 32'(ia.resp_valid), 32'd1);
      chk("hold_a_res", ia.result, 32'h4110_0000);
      chk("hold_b_rv", 32'(ib.resp_valid), 32'd0);
      chk("hold_b_ready", 32'(ib.req_ready), 32'd0);
      step();
    end
    chk("hold_last_rv", 32'(ia.resp_valid), 32'd1);
    chk("hold_last_res", ia.result, 32'h4110_0000);
    ia.resp_ready = 1'b1;
    step();
    chk("hold_idle", 32'(busy), 32'd0);
    chk("wait_b_ready", 32'(ib.req_ready), 32'd1);
    step();
    ib.req_valid = 1'b0;
    step();
    chk("wait_b_rv", 32'(ib.resp_valid), 32'd1);
    chk("wait_b_res", ib.result, 32'h40C0_0000);
    chk("wait_a_rv", 32'(ia.resp_valid), 32'd0);
    step();

    // Reset in BUSY abandons the operation
    ia.num1 = 32'h4000_0000;
    ia.num2 = 32'h4040_0000;
    ia.req_valid = 1'b1;
    ia.resp_ready = 1'b1;
    #1;
    chk("abort_ready", 32'(ia.req_ready), 32'd1);
    step();
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    ia.req_valid = 1'b0;
    step();
    chk("abort_busy_clr", 32'(busy), 32'd0);
    chk("abort_rv", 32'(ia.resp_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("abort_rv2", 32'(ia.resp_valid), 32'd0);
    step();
    chk("abort_rv3", 32'(ia.resp_valid), 32'd0);
    serve_a("mul3x3", 32'h4040_0000, 32'h4040_0000,
            2'b00, 32'h4110_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter MUL_LATENCY, default 1, range 1..15: number of BUSY cycles between operand capture and result capture.
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 a_req_valid  input  1  requester A has an operation pending.
REQ-005 a_req_ready  output  1  requester A's operation is accepted this cycle.
REQ-006 a_num1, a_num2  input  32 each  requester A IEEE754 single-precision operands.
REQ-007 a_rounding_mode  input  2  requester A rounding mode: 00 nearest-even, 01 toward zero, 10 +inf, 11 -inf.
REQ-008 a_resp_valid  output  1  a_result holds requester A's result.
REQ-009 a_resp_ready  input  1  requester A consumes its result.
REQ-010 a_result  output  32  requester A product.
REQ-011 b_req_valid, b_req_ready, b_num1, b_num2, b_rounding_mode, b_resp_valid, b_resp_ready, b_result: identical to REQ-004..010, for requester B.
REQ-012 busy  output  1  FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
- IDLE: at least one req_valid is high -> grant one requester, capture its num1, num2 and rounding_mode into operand registers, load the counter with MUL_LATENCY, go to BUSY.
REQ-014 Grant in IDLE SHALL be round-robin.
- Priority pointer resets to A.
- A lone valid is granted regardless of the pointer.
- If both are valid, the requester named by the pointer wins.
REQ-015 x_req_ready SHALL be combinational, high only in IDLE and only for the granted requester; the other requester's ready SHALL stay low.
REQ-016 BUSY: the counter SHALL decrement every cycle.
- When the counter equals 1, the fp_multiplier output SHALL be latched into the result register and the FSM SHALL go to RESP.
REQ-017 Required latency: acceptance in cycle T gives owner resp_valid high from cycle T+1+MUL_LATENCY.
REQ-018 RESP: the owner's resp_valid SHALL be high and its result SHALL hold the latched value, stable until handshake.
- The non-owner's resp_valid SHALL be 0.
- Both result outputs SHALL be driven from the single result register.
REQ-019 Owner resp_ready high in RESP -> next state IDLE, and the pointer SHALL change to the requester that was not the owner.
- No new request SHALL be accepted in that same cycle; the earliest next acceptance is one cycle later.
REQ-020 The operand registers SHALL not change outside IDLE acceptance, so requester input changes during BUSY or RESP SHALL not affect the result.
REQ-021 The non-owner's resp_ready SHALL be ignored.
- A req_valid arriving during BUSY or RESP SHALL wait, unacknowledged, until IDLE.
REQ-022 Arithmetic, rounding, and special-value handling SHALL be solely those of the instantiated fp_multiplier; the arbiter SHALL not alter any result bit.

Reset
REQ-023 When rst_n is low at a clock edge, the following SHALL be the registered state after that edge:
- state IDLE, pointer A, counter 0, operand and result registers 0;
- outputs a/b_resp_valid 0, busy 0.
REQ-024 While rst_n is low, both req_ready outputs SHALL be 0.
REQ-025 Reset asserted in BUSY or RESP SHALL abandon the operation, with no resp_valid afterward for that operation.

Structure
REQ-026 Shared package fp_ctrl_pkg SHALL hold the following, which no other module SHALL redefine:
- state encoding;
- requester ID constants REQ_A and REQ_B;
- FP_WIDTH = 32;
- RM_WIDTH = 2;
- the rounding-mode constants.
REQ-027 Exactly one sub-module instance SHALL exist: fp_multiplier (ports num1, num2, rounding_mode, result), fed from the operand registers.

Verification
REQ-028 Reset, then A requests 40000000 x 40400000, rm 00, resp_ready high -> a_resp_valid at T+2 (MUL_LATENCY 1), a_result 40C00000; B outputs idle.
REQ-029 A: 3FE87CF5 x 3F0CF1E1, rm 00, then rm 01 -> each a_result equals the standalone fp_multiplier output for the same inputs and mode.
REQ-030 After reset, A and B both valid and held:
- A requests 3F800000 x 3F800000, B requests 40000000 x 40000000.
- Required: A served first with 3F800000, then B with 40800000; grants alternate on every later collision.
REQ-031 Owner resp_ready low for 5 cycles in RESP -> resp_valid and result held stable; requester operand changes during that time have no effect.
REQ-032 rst_n low for one cycle mid-BUSY:
- Required: next cycle IDLE and no resp_valid.
- Then a fresh A request 40400000 x 40400000 -> a_result 41100000.
